// File: rtl/alu_serial_n_pkg.sv
// Shared definitions for the digit-serial ALU: opcode encodings and FSM states.
package alu_serial_n_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam logic [2:0] OP_NOR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_serial_n_digit.sv
// Combinational DIGIT-bit ALU slice with ripple carry; exposes the carry into its top bit.
// Build option: ALU_NOR_EN adds opcode 100 = NOR; otherwise 100 yields 0.
module alu_serial_n_digit
    import alu_serial_n_pkg::*;
#(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    input  logic             binvt,
    input  logic [2:0]       op,
    output logic [DIGIT-1:0] out,
    output logic             cout,
    output logic             cin_top
);

    logic [DIGIT-1:0] b_eff;
    logic [DIGIT-1:0] sum;
    logic [DIGIT:0]   c;

    always_comb begin
        b_eff = binvt ? ~b : b;
        sum   = '0;
        c     = '0;
        c[0]  = cin;
        for (int i = 0; i < int'(DIGIT); i++) begin
            sum[i]   = a[i] ^ b_eff[i] ^ c[i];
            c[i+1]   = (a[i] & b_eff[i]) | (a[i] & c[i]) | (b_eff[i] & c[i]);
        end
        cout    = c[DIGIT];
        cin_top = c[DIGIT-1];

        // Logic ops use the raw b; unknown opcodes produce zero.
        case (op)
            OP_AND:                 out = a & b;
            OP_OR:                  out = a | b;
            OP_ADD, OP_SUB, OP_SLT: out = sum;
`ifdef ALU_NOR_EN
            OP_NOR:                 out = ~(a | b);
`endif
            default:                out = '0;
        endcase
    end

endmodule

// File: rtl/alu_serial_n.sv
// Digit-serial ALU behind valid/ready handshakes; processes DIGIT bits per clock LSB first.
// Build option: ALU_NOR_EN enables the NOR opcode in the digit slice.
module alu_serial_n
    import alu_serial_n_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             oflo,
    output logic             set,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, alu_out_q, alu_out_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic             oflo_q, oflo_d, set_q, set_d, zero_q, zero_d;

    logic [DIGIT-1:0] dig_a, dig_b, dig_out;
    logic             dig_cout, dig_cin_top;
    logic             ov, less;

    // Select the digit addressed by the step counter.
    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (cnt_q == CW'(k)) begin
                dig_a = a_q[k*DIGIT +: DIGIT];
                dig_b = b_q[k*DIGIT +: DIGIT];
            end
        end
    end

    alu_serial_n_digit #(.DIGIT(DIGIT)) u_digit (
        .a       (dig_a),
        .b       (dig_b),
        .cin     (carry_q),
        .binvt   (op_q[2]),
        .op      (op_q),
        .out     (dig_out),
        .cout    (dig_cout),
        .cin_top (dig_cin_top)
    );

    // Signed compare uses sum sign corrected by overflow, valid on the MSB step.
    assign ov   = dig_cin_top ^ dig_cout;
    assign less = dig_out[DIGIT-1] ^ ov;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        alu_out_d   = alu_out_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        oflo_d      = oflo_q;
        set_d       = set_q;
        zero_d      = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    op_d       = operation;
                    carry_d    = operation[2];
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int k = 0; k < int'(N); k++) begin
                    if (cnt_q == CW'(k)) begin
                        res_d[k*DIGIT +: DIGIT] = dig_out;
                    end
                end
                carry_d = dig_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d       = '0;
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    alu_out_d   = res_d;
                    oflo_d      = 1'b0;
                    set_d       = 1'b0;
                    case (op_q)
                        OP_ADD, OP_SUB: oflo_d = ov;
                        OP_SLT: begin
                            oflo_d    = ov;
                            set_d     = less;
                            alu_out_d = {{(WIDTH-1){1'b0}}, less};
                        end
                        default: ;
                    endcase
                    zero_d = (alu_out_d == '0);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            alu_out_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            oflo_q      <= 1'b0;
            set_q       <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            alu_out_q   <= alu_out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            oflo_q      <= oflo_d;
            set_q       <= set_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign oflo      = oflo_q;
    assign set       = set_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_serial_n.sv
// Directed bench for alu_serial_n: DIGIT=1 and DIGIT=4 instances, handshake, backpressure, reset.
module tb_alu_serial_n;

    logic        clk = 1'b0;
    logic        reset;

    logic        iv1, ir1, ov1, ordy1, of1, st1, z1;
    logic [31:0] a1, b1, out1;
    logic [2:0]  op1;

    logic        iv4, ir4, ov4, ordy4, of4, st4, z4;
    logic [31:0] a4, b4, out4;
    logic [2:0]  op4;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] r_out;
    logic        r_of, r_st, r_z, r_ov, r_ir;
    int          lat;

    always #5 clk = ~clk;

    alu_serial_n #(.WIDTH(32), .DIGIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .operation(op1), .out_valid(ov1), .out_ready(ordy1), .alu_out(out1),
        .oflo(of1), .set(st1), .zero(z1)
    );

    alu_serial_n #(.WIDTH(32), .DIGIT(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .operation(op4), .out_valid(ov4), .out_ready(ordy4), .alu_out(out4),
        .oflo(of4), .set(st4), .zero(z4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            r_out = out1; r_of = of1; r_st = st1; r_z = z1; r_ov = ov1; r_ir = ir1;
        end else begin
            r_out = out4; r_of = of4; r_st = st4; r_z = z4; r_ov = ov4; r_ir = ir4;
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (sel == 0) begin iv1 = v; op1 = op; a1 = a; b1 = b; end
        else          begin iv4 = v; op4 = op; a4 = a; b4 = b; end
    endtask

    // Launch one operation and wait (bounded) for out_valid; result left unaccepted.
    task automatic start_op(input int sel, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        drive(sel, 1'b1, op, a, b);
        @(posedge clk); #1;
        drive(sel, 1'b0, op, a, b);
        lat = 0;
        sample(sel);
        while (!r_ov && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            sample(sel);
        end
    endtask

    task automatic accept(input int sel);
        if (sel == 0) ordy1 = 1'b1; else ordy4 = 1'b1;
        @(posedge clk); #1;
        if (sel == 0) ordy1 = 1'b0; else ordy4 = 1'b0;
        sample(sel);
        chk("accept_in_ready", 32'(r_ir), 32'd1);
        chk("accept_out_valid", 32'(r_ov), 32'd0);
    endtask

    task automatic run_op(input string tag, input int sel, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] e_out,
                          input logic e_of, input logic e_st, input logic e_z);
        start_op(sel, op, a, b);
        chk({tag, "_out"},  r_out, e_out);
        chk({tag, "_oflo"}, 32'(r_of), 32'(e_of));
        chk({tag, "_set"},  32'(r_st), 32'(e_st));
        chk({tag, "_zero"}, 32'(r_z), 32'(e_z));
        accept(sel);
    endtask

    initial begin
        logic [31:0] nor_exp;
        reset = 1'b1;
        iv1 = 0; ordy1 = 0; a1 = 0; b1 = 0; op1 = 0;
        iv4 = 0; ordy4 = 0; a4 = 0; b4 = 0; op4 = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        sample(0);
        chk("rst_in_ready", 32'(r_ir), 32'd1);
        chk("rst_out_valid", 32'(r_ov), 32'd0);
        chk("rst_alu_out", r_out, 32'd0);
        chk("rst_zero", 32'(r_z), 32'd1);
        chk("rst_oflo", 32'(r_of), 32'd0);
        chk("rst_set", 32'(r_st), 32'd0);

        start_op(0, 3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("add_ovf_latency", 32'(lat), 32'd32);
        chk("add_ovf_out", r_out, 32'h8000_0000);
        chk("add_ovf_oflo", 32'(r_of), 32'd1);
        chk("add_ovf_zero", 32'(r_z), 32'd0);
        chk("add_ovf_set", 32'(r_st), 32'd0);
        accept(0);

        run_op("sub_eq",   0, 3'b110, 32'd5,          32'd5,          32'd0,          0, 0, 1);
        run_op("and",      0, 3'b000, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  0, 0, 0);
        run_op("or",       0, 3'b001, 32'hF0F0_F0F0,  32'h0F0F_0000,  32'hFFFF_F0F0,  0, 0, 0);
        run_op("sub_neg",  0, 3'b110, 32'd3,          32'd5,          32'hFFFF_FFFE,  0, 0, 0);
        run_op("add_wrap", 0, 3'b010, 32'hFFFF_FFFF,  32'd1,          32'd0,          0, 0, 1);
        run_op("slt_m1_1", 0, 3'b111, 32'hFFFF_FFFF,  32'd1,          32'd1,          0, 1, 0);
        run_op("slt_min_1",0, 3'b111, 32'h8000_0000,  32'd1,          32'd1,          1, 1, 0);
        run_op("slt_1_m1", 0, 3'b111, 32'd1,          32'hFFFF_FFFF,  32'd0,          0, 0, 1);
        run_op("unk_op",   0, 3'b011, 32'd5,          32'd5,          32'd0,          0, 0, 1);

        // Backpressure with an in_valid pulse that must be ignored.
        start_op(0, 3'b010, 32'd1, 32'd2);
        chk("bp_first", r_out, 32'd3);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) drive(0, 1'b1, 3'b000, 32'hDEAD_BEEF, 32'h0);
            if (i == 4) drive(0, 1'b0, 3'b000, 32'h0, 32'h0);
            @(posedge clk); #1;
            sample(0);
            chk("bp_out_valid", 32'(r_ov), 32'd1);
            chk("bp_in_ready", 32'(r_ir), 32'd0);
            chk("bp_alu_out", r_out, 32'd3);
        end
        accept(0);
        run_op("after_bp", 0, 3'b010, 32'd10, 32'd20, 32'd30, 0, 0, 0);

        // Reset mid-run; previous result 30 must be cleared.
        drive(0, 1'b1, 3'b010, 32'h1234_5678, 32'h1111_1111);
        @(posedge clk); #1;
        drive(0, 1'b0, 3'b010, 32'h0, 32'h0);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sample(0);
        chk("midrst_out_valid", 32'(r_ov), 32'd0);
        chk("midrst_in_ready", 32'(r_ir), 32'd1);
        chk("midrst_alu_out", r_out, 32'd0);
        chk("midrst_zero", 32'(r_z), 32'd1);
        run_op("post_rst", 0, 3'b010, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 0, 0, 0);

        // DIGIT=4 instance.
        start_op(1, 3'b010, 32'h0000_FFFF, 32'd1);
        chk("d4_latency", 32'(lat), 32'd8);
        chk("d4_add_out", r_out, 32'h0001_0000);
        accept(1);
        run_op("d4_sub",     1, 3'b110, 32'h10,        32'h20, 32'hFFFF_FFF0, 0, 0, 0);
        run_op("d4_slt_min", 1, 3'b111, 32'h8000_0000, 32'd1,  32'd1,        1, 1, 0);
        run_op("d4_add_ovf", 1, 3'b010, 32'h7FFF_FFFF, 32'd1,  32'h8000_0000, 1, 0, 0);
`ifdef ALU_NOR_EN
        nor_exp = 32'hFFFF_FFFF;
`else
        nor_exp = 32'h0;
`endif
        run_op("d4_nor", 1, 3'b100, 32'h0, 32'h0, nor_exp, 0, 0, (nor_exp == 32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
